// File: rtl/gcd_job_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_job_feeder
//  Function : Buffers operand pairs from a valid/ready stream, issues each one
//             to a GCD core through its rst/start/rdy handshake (with a
//             timeout guard) and returns results, in input order, on a
//             valid/ready stream.
//  Options  : GCD_FEEDER_ABS_EN - popped operands are read as two's
//             complement and replaced by their absolute value.
//  Revision : 1.0  initial release
// ============================================================================
module gcd_job_feeder #(
   parameter int unsigned NBits      = 16,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned MAX_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBits-1:0] in_x,
   input  logic [NBits-1:0] in_y,
   output logic             core_rst,
   output logic             core_start,
   output logic [NBits-1:0] core_xi,
   output logic [NBits-1:0] core_yi,
   input  logic [NBits-1:0] core_xo,
   input  logic             core_rdy,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBits-1:0] out_gcd,
   output logic             out_err,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_END = CW'(MAX_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CLR  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [NBits-1:0] mem_x_q [DEPTH];
   logic [NBits-1:0] mem_y_q [DEPTH];

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [1:0]       state_q,  state_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [NBits-1:0] xi_q,     xi_d;
   logic [NBits-1:0] yi_q,     yi_d;
   logic [NBits-1:0] gcd_q,    gcd_d;
   logic             err_q,    err_d;

   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic [NBits-1:0] head_x_raw;
   logic [NBits-1:0] head_y_raw;
   logic [NBits-1:0] head_x;
   logic [NBits-1:0] head_y;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign in_ready   = !fifo_full && !rst;
   assign push       = in_valid && in_ready;

   assign head_x_raw = mem_x_q[rd_ptr_q[AW-1:0]];
   assign head_y_raw = mem_y_q[rd_ptr_q[AW-1:0]];

`ifdef GCD_FEEDER_ABS_EN
   // The most negative value negates to itself and is then read as unsigned.
   assign head_x = head_x_raw[NBits-1] ? (~head_x_raw + NBits'(1)) : head_x_raw;
   assign head_y = head_y_raw[NBits-1] ? (~head_y_raw + NBits'(1)) : head_y_raw;
`else
   assign head_x = head_x_raw;
   assign head_y = head_y_raw;
`endif

   // Outputs are forced to their idle values for as long as rst is high.
   assign core_rst   = rst || (state_q == ST_CLR);
   assign core_start = !rst && (state_q == ST_RUN);
   assign core_xi    = xi_q;
   assign core_yi    = yi_q;
   assign out_valid  = !rst && (state_q == ST_RESP);
   assign out_gcd    = gcd_q;
   assign out_err    = err_q;
   assign busy       = !rst && ((state_q != ST_IDLE) || !fifo_empty);

   // Job sequencing and FIFO pointer updates.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      xi_d     = xi_q;
      yi_d     = yi_q;
      gcd_d    = gcd_q;
      err_d    = err_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               xi_d     = head_x;
               yi_d     = head_y;
               // A zero operand never reaches the core; the result is 0.
               if ((head_x == '0) || (head_y == '0)) begin
                  gcd_d   = '0;
                  err_d   = 1'b0;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_CLR: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (core_rdy) begin
               gcd_d   = core_xo;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_END) begin
               gcd_d   = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_RESP: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and result registers; reset discards any in-flight job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         xi_q     <= '0;
         yi_q     <= '0;
         gcd_q    <= '0;
         err_q    <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         xi_q     <= xi_d;
         yi_q     <= yi_d;
         gcd_q    <= gcd_d;
         err_q    <= err_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // FIFO storage; contents are don't-care while the pointers say empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_x_q[wr_ptr_q[AW-1:0]] <= in_x;
         mem_y_q[wr_ptr_q[AW-1:0]] <= in_y;
      end
   end

endmodule
`default_nettype wire
